sel_parity_misr: RTL

- Pipelined, parametrised successor of the team's select/polarity/parity cone.
- Each of CHANNELS lanes selects one of four shared DATA_W-bit buses under per-lane sel/pol control.
- Lane words are XOR-reduced to a parity word and AND-reduced to an all-ones flag.
- Results leave over a valid/ready stream and are compacted into a MISR signature for equivalence runs on mapped netlists.

---
 rtl/sel_parity_misr.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/sel_parity_misr.sv
// sel_parity_misr
//   Two-stage select/polarity/parity pipeline with a valid/ready output
//   stream, a saturating transfer counter and an optional MISR signature.
//
//   Optional feature macro: SEL_PARITY_MISR_EN
//     defined   -> signature register and MISR feedback are built
//     undefined -> signature is tied to 0; clr only clears xfer_cnt
//
//   Ports
//     clk, rst                  clock, synchronous active-high reset
//     in_valid / in_ready       input handshake (in_ready depends combinationally on out_ready)
//     sel, pol   [CHANNELS]     per-lane select and polarity
//     bus_a..bus_d [DATA_W]     shared data buses
//     out_valid / out_ready     output handshake
//     par        [DATA_W]       XOR of all lane words
//     all_one                   AND of all lane words is all ones
//     clr                       synchronous clear of signature and counter
//     signature  [MISR_W]       MISR state
//     xfer_cnt   [CNT_W]        saturating count of output transfers

// Per-lane word selection: pol picks the true (a/b) or inverted (c/d) pair.
module sel_parity_misr_lane #(
    parameter int DATA_W = 4
) (
    input  logic              sel_i,
    input  logic              pol_i,
    input  logic [DATA_W-1:0] bus_a_i,
    input  logic [DATA_W-1:0] bus_b_i,
    input  logic [DATA_W-1:0] bus_c_i,
    input  logic [DATA_W-1:0] bus_d_i,
    output logic [DATA_W-1:0] m_o
);
    always_comb begin
        if (pol_i) m_o = ~(sel_i ? bus_c_i : bus_d_i);
        else       m_o =   sel_i ? bus_a_i : bus_b_i;
    end
endmodule

module sel_parity_misr #(
    parameter int                CHANNELS  = 4,
    parameter int                DATA_W    = 4,
    parameter int                MISR_W    = 16,
    parameter logic [MISR_W-1:0] MISR_POLY = 16'h1021,
    parameter int                CNT_W     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CHANNELS-1:0] sel,
    input  logic [CHANNELS-1:0] pol,
    input  logic [DATA_W-1:0]   bus_a,
    input  logic [DATA_W-1:0]   bus_b,
    input  logic [DATA_W-1:0]   bus_c,
    input  logic [DATA_W-1:0]   bus_d,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   par,
    output logic                all_one,
    input  logic                clr,
    output logic [MISR_W-1:0]   signature,
    output logic [CNT_W-1:0]    xfer_cnt
);
    logic [CHANNELS-1:0][DATA_W-1:0] m_d, m_q;
    logic                            s1_valid_q, s2_valid_q;
    logic [DATA_W-1:0]               par_d, par_q;
    logic                            all_one_d, all_one_q;
    logic                            s1_load, s2_load, in_fire, out_fire;
    logic [CNT_W-1:0]                cnt_d, cnt_q;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        sel_parity_misr_lane #(.DATA_W(DATA_W)) u_lane (
            .sel_i   (sel[c]),
            .pol_i   (pol[c]),
            .bus_a_i (bus_a),
            .bus_b_i (bus_b),
            .bus_c_i (bus_c),
            .bus_d_i (bus_d),
            .m_o     (m_d[c])
        );
    end

    // A stage may load when it is empty or when the stage after it drains.
    assign s2_load  = !s2_valid_q | out_ready;
    assign s1_load  = !s1_valid_q | s2_load;
    assign in_ready = s1_load;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = s2_valid_q & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            m_q        <= '0;
        end else if (s1_load) begin
            s1_valid_q <= in_valid;
            if (in_valid) m_q <= m_d;
        end
    end

    always_comb begin
        logic [DATA_W-1:0] and_w;
        par_d = '0;
        and_w = '1;
        for (int c = 0; c < CHANNELS; c++) begin
            par_d = par_d ^ m_q[c];
            and_w = and_w & m_q[c];
        end
        all_one_d = &and_w;
    end

    // Stage-2 data only moves on a load with a valid stage-1 word, so it
    // stays stable while the output is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            par_q      <= '0;
            all_one_q  <= 1'b0;
        end else if (s2_load) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                par_q     <= par_d;
                all_one_q <= all_one_d;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign par       = par_q;
    assign all_one   = all_one_q;

    always_comb begin
        cnt_d = cnt_q;
        if (out_fire && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst || clr) cnt_q <= '0;
        else            cnt_q <= cnt_d;
    end

    assign xfer_cnt = cnt_q;

`ifdef SEL_PARITY_MISR_EN
    logic [MISR_W-1:0] sig_d, sig_q;

    // Galois MISR: shift, fold taps when the MSB falls out, inject {par, all_one}.
    always_comb begin
        sig_d = sig_q;
        if (out_fire)
            sig_d = (sig_q << 1)
                  ^ (sig_q[MISR_W-1] ? MISR_POLY : '0)
                  ^ MISR_W'({par_q, all_one_q});
    end

    // clr wins over a same-cycle transfer: that result is not folded in.
    always_ff @(posedge clk) begin
        if (rst || clr) sig_q <= '0;
        else            sig_q <= sig_d;
    end

    assign signature = sig_q;
`else
    assign signature = '0;
`endif

endmodule
